// File: rtl/conn_cmd_rx.sv
// Connector command receiver: synchronises the low-active rw_cmd strobe, decodes
// write/read frames, buffers write data in a FWFT FIFO and issues read requests.
module conn_cmd_rx #(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int MAX_LEN = 512,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rw_cmd,
    input  logic [15:0]   conn_f_in,
    output logic [15:0]   data_out,
    output logic          data_valid,
    input  logic          data_ready,
    output logic          rd_req,
    output logic [14:0]   rd_len,
    input  logic          rd_ack,
    output logic [AW:0]   fifo_level,
    output logic          busy,
    output logic          frame_err,
    output logic          ovf
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);
    localparam logic [AW:0]   LVL_FULL  = (AW+1)'(DEPTH);
    localparam logic [14:0]   LEN_MAX   = 15'(MAX_LEN);

    typedef enum logic [1:0] {ST_IDLE, ST_WDATA, ST_RD_REQ} state_t;

    state_t        r_state, w_next_state;
    logic          r_s1, r_s2, r_s3;
    logic [14:0]   r_remaining, w_rem_nxt;
    logic [TW-1:0] r_timer, w_timer_nxt;
    logic          r_rd_req, w_rd_req_nxt;
    logic [14:0]   r_rd_len, w_rd_len_nxt;
    logic          r_frame_err, w_frame_err_nxt;
    logic          r_ovf;
    logic          w_push_req;

    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_level;

    logic          w_strobe, w_len_ok, w_pop, w_push, w_drop, w_data_valid;
    logic [14:0]   w_len;

    // Falling edge of the synchronised strobe; s3 reset high so reset never fakes an edge.
    assign w_strobe = !r_s2 && r_s3;
    assign w_len    = conn_f_in[14:0];
    assign w_len_ok = (w_len != 15'd0) && (w_len <= LEN_MAX);

    always_comb begin
        w_next_state    = r_state;
        w_frame_err_nxt = 1'b0;
        w_push_req      = 1'b0;
        w_rem_nxt       = r_remaining;
        w_timer_nxt     = r_timer;
        w_rd_req_nxt    = r_rd_req;
        w_rd_len_nxt    = r_rd_len;
        case (r_state)
            ST_IDLE: begin
                if (w_strobe) begin
                    if (!w_len_ok) begin
                        w_frame_err_nxt = 1'b1;
                    end else if (conn_f_in[15]) begin
                        w_next_state = ST_RD_REQ;
                        w_rd_req_nxt = 1'b1;
                        w_rd_len_nxt = w_len;
                    end else begin
                        w_next_state = ST_WDATA;
                        w_rem_nxt    = w_len;
                        w_timer_nxt  = '0;
                    end
                end
            end
            ST_WDATA: begin
                if (w_strobe) begin
                    w_push_req  = 1'b1;
                    w_timer_nxt = '0;
                    if (r_remaining != 15'd0) w_rem_nxt = r_remaining - 15'd1;
                    if (r_remaining == 15'd1) w_next_state = ST_IDLE;
                end else if (r_timer == TIMER_MAX) begin
                    w_frame_err_nxt = 1'b1;
                    w_timer_nxt     = '0;
                    w_next_state    = ST_IDLE;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            ST_RD_REQ: begin
                if (w_strobe) w_frame_err_nxt = 1'b1;
                if (rd_ack && r_rd_req) begin
                    w_rd_req_nxt = 1'b0;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign w_data_valid = (r_level != '0);
    assign w_pop        = w_data_valid && data_ready;
    assign w_push       = w_push_req && ((r_level < LVL_FULL) || w_pop);
    assign w_drop       = w_push_req && !w_push;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1        <= 1'b1;
            r_s2        <= 1'b1;
            r_s3        <= 1'b1;
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_timer     <= '0;
            r_rd_req    <= 1'b0;
            r_rd_len    <= '0;
            r_frame_err <= 1'b0;
            r_ovf       <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
        end else begin
            r_s1        <= rw_cmd;
            r_s2        <= r_s1;
            r_s3        <= r_s2;
            r_state     <= w_next_state;
            r_remaining <= w_rem_nxt;
            r_timer     <= w_timer_nxt;
            r_rd_req    <= w_rd_req_nxt;
            r_rd_len    <= w_rd_len_nxt;
            r_frame_err <= w_frame_err_nxt;
            if (w_drop) r_ovf <= 1'b1;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) r_mem[r_wr_ptr] <= conn_f_in;
    end

    assign data_out   = w_data_valid ? r_mem[r_rd_ptr] : 16'h0000;
    assign data_valid = w_data_valid;
    assign rd_req     = r_rd_req;
    assign rd_len     = r_rd_len;
    assign fifo_level = r_level;
    assign busy       = (r_state != ST_IDLE);
    assign frame_err  = r_frame_err;
    assign ovf        = r_ovf;

endmodule
